// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters.
// Data wins ties until a fetch has waited MAX_DATA_STREAK data grants.
module mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_r,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_r,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    D_BUSY
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              we_q, we_d;
  logic [1:0]        wmask_q, wmask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic fetch_due;
  assign fetch_due = if_req && (streak_q == STREAK_MAX);

  // Arbitrate in IDLE and latch the winner; wait for mem_ready when busy
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    we_d     = we_q;
    wmask_d  = wmask_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !fetch_due) begin
          state_d = D_BUSY;
          we_d    = d_we;
          wmask_d = d_wmask;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (if_req && streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
        end else if (if_req) begin
          state_d  = IF_BUSY;
          we_d     = 1'b0;
          wmask_d  = 2'b00;
          addr_d   = if_addr;
          streak_d = 4'd0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and memory-port registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      we_q     <= 1'b0;
      wmask_q  <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      we_q     <= we_d;
      wmask_q  <= wmask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_en    = (state_q != IDLE);
  assign owner     = (state_q == D_BUSY);
  assign mem_we    = we_q;
  assign mem_wmask = wmask_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // A reset in the completing cycle suppresses the strobe
  assign if_r     = (state_q == IF_BUSY) && mem_ready && !reset;
  assign d_r      = (state_q == D_BUSY) && mem_ready && !reset;
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus a starvation sequence.
// Each table row is one clock cycle of inputs and expected outputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_r;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_wmask;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_r;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_r(if_r),
    .d_req(d_req),
    .d_we(d_we),
    .d_wmask(d_wmask),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_r(d_r),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_wmask(mem_wmask),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .owner(owner)
  );

  typedef struct {
    logic        rst;
    logic        ifq;
    logic [15:0] ia;
    logic        dq;
    logic        we;
    logic [1:0]  wm;
    logic [15:0] da;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        rdy;
    logic        en;
    logic        own;
    logic        mwe;
    logic [1:0]  mwm;
    logic [15:0] maddr;
    logic [15:0] mwd;
    logic        ifr;
    logic        dr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic ifq, input logic [15:0] ia,
    input logic dq, input logic we, input logic [1:0] wm,
    input logic [15:0] da, input logic [15:0] wd,
    input logic [15:0] rd, input logic rdy,
    input logic en, input logic own, input logic mwe,
    input logic [1:0] mwm, input logic [15:0] maddr,
    input logic [15:0] mwd, input logic ifr, input logic dr);
    vec_t v;
    v.rst = rst; v.ifq = ifq; v.ia = ia; v.dq = dq;
    v.we = we; v.wm = wm; v.da = da; v.wd = wd;
    v.rd = rd; v.rdy = rdy; v.en = en; v.own = own;
    v.mwe = mwe; v.mwm = mwm; v.maddr = maddr;
    v.mwd = mwd; v.ifr = ifr; v.dr = dr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset     = v.rst;
    if_req    = v.ifq;
    if_addr   = v.ia;
    d_req     = v.dq;
    d_we      = v.we;
    d_wmask   = v.wm;
    d_addr    = v.da;
    d_wdata   = v.wd;
    mem_rdata = v.rd;
    mem_ready = v.rdy;
  endtask

  logic [39:0] got_w;
  logic [39:0] exp_w;
  logic [3:0]  got_s;
  logic [3:0]  exp_s;
  logic        s_en;
  logic        s_own;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_wmask = '0;
    d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    tbl.push_back(mk(1,0,16'h0,0,0,2'b00,16'h0,16'h0,16'h0,0, 0,0,0,2'b00,16'h0,16'h0,0,0));
    // fetch only, ready on 3rd busy cycle
    tbl.push_back(mk(0,1,16'h3000,0,0,2'b00,16'h0,16'h0,16'h0,0, 0,0,0,2'b00,16'h0,16'h0,0,0));
    tbl.push_back(mk(0,1,16'h3000,0,0,2'b00,16'h0,16'h0,16'h0,0, 1,0,0,2'b00,16'h3000,16'h0,0,0));
    tbl.push_back(mk(0,1,16'h3000,0,0,2'b00,16'h0,16'h0,16'h0,0, 1,0,0,2'b00,16'h3000,16'h0,0,0));
    tbl.push_back(mk(0,1,16'h3000,0,0,2'b00,16'h0,16'h0,16'hF025,1, 1,0,0,2'b00,16'h3000,16'h0,1,0));
    tbl.push_back(mk(0,0,16'h0,0,0,2'b00,16'h0,16'h0,16'h0,0, 0,0,0,2'b00,16'h3000,16'h0,0,0));
    // spurious ready in idle
    tbl.push_back(mk(0,0,16'h0,0,0,2'b00,16'h0,16'h0,16'h1234,1, 0,0,0,2'b00,16'h3000,16'h0,0,0));
    tbl.push_back(mk(0,0,16'h0,0,0,2'b00,16'h0,16'h0,16'h1234,1, 0,0,0,2'b00,16'h3000,16'h0,0,0));
    // simultaneous requests, data first
    tbl.push_back(mk(0,1,16'h3002,1,0,2'b00,16'h4000,16'h0,16'h0,1, 0,0,0,2'b00,16'h3000,16'h0,0,0));
    tbl.push_back(mk(0,1,16'h3002,1,0,2'b00,16'h4000,16'h0,16'hBEEF,1, 1,1,0,2'b00,16'h4000,16'h0,0,1));
    tbl.push_back(mk(0,1,16'h3002,0,0,2'b00,16'h0,16'h0,16'h0,0, 0,0,0,2'b00,16'h4000,16'h0,0,0));
    tbl.push_back(mk(0,1,16'h3002,0,0,2'b00,16'h0,16'h0,16'h5555,1, 1,0,0,2'b00,16'h3002,16'h0,1,0));
    // byte write high byte
    tbl.push_back(mk(0,0,16'h0,1,1,2'b10,16'h4001,16'hAB00,16'h0,0, 0,0,0,2'b00,16'h3002,16'h0,0,0));
    tbl.push_back(mk(0,0,16'h0,1,1,2'b10,16'h4001,16'hAB00,16'h0,0, 1,1,1,2'b10,16'h4001,16'hAB00,0,0));
    tbl.push_back(mk(0,0,16'h0,1,1,2'b10,16'h4001,16'hAB00,16'h0,1, 1,1,1,2'b10,16'h4001,16'hAB00,0,1));
    tbl.push_back(mk(0,0,16'h0,0,0,2'b00,16'h0,16'h0,16'h0,0, 0,0,1,2'b10,16'h4001,16'hAB00,0,0));
    // reset in 2nd cycle of a data read
    tbl.push_back(mk(0,0,16'h0,1,0,2'b00,16'h4000,16'h1111,16'h0,0, 0,0,1,2'b10,16'h4001,16'hAB00,0,0));
    tbl.push_back(mk(0,0,16'h0,1,0,2'b00,16'h4000,16'h1111,16'h0,0, 1,1,0,2'b00,16'h4000,16'h1111,0,0));
    tbl.push_back(mk(1,0,16'h0,1,0,2'b00,16'h4000,16'h1111,16'h7777,1, 1,1,0,2'b00,16'h4000,16'h1111,0,0));
    tbl.push_back(mk(0,1,16'h3004,0,0,2'b00,16'h0,16'h0,16'h0,1, 0,0,0,2'b00,16'h0,16'h0,0,0));
    tbl.push_back(mk(0,1,16'h3004,0,0,2'b00,16'h0,16'h0,16'hA5A5,1, 1,0,0,2'b00,16'h3004,16'h0,1,0));
    tbl.push_back(mk(0,0,16'h0,0,0,2'b00,16'h0,16'h0,16'h0,0, 0,0,0,2'b00,16'h3004,16'h0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      got_w = {mem_en, owner, mem_we, mem_wmask, mem_addr, mem_wdata, if_r, d_r};
      exp_w = {tbl[i].en, tbl[i].own, tbl[i].mwe, tbl[i].mwm,
               tbl[i].maddr, tbl[i].mwd, tbl[i].ifr, tbl[i].dr};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL vec%0d outputs: got %h expected %h", i, got_w, exp_w);
      end
      if (tbl[i].ifr) begin
        checks++;
        if (if_rdata !== tbl[i].rd) begin
          errors++;
          $display("FAIL vec%0d if_rdata: got %h expected %h", i, if_rdata, tbl[i].rd);
        end
      end
      if (tbl[i].dr && !tbl[i].mwe) begin
        checks++;
        if (d_rdata !== tbl[i].rd) begin
          errors++;
          $display("FAIL vec%0d d_rdata: got %h expected %h", i, d_rdata, tbl[i].rd);
        end
      end
    end

    // starvation: both held, ready tied high -> D,D,D,D,I repeating
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      reset = 1'b0; if_req = 1'b1; if_addr = 16'h3006;
      d_req = 1'b1; d_we = 1'b0; d_wmask = 2'b00;
      d_addr = 16'h4002; d_wdata = 16'h0;
      mem_rdata = 16'h0; mem_ready = 1'b1;
      #1;
      s_en  = (c % 2) == 1;
      s_own = s_en && ((c / 2) % 5 != 4);
      exp_s = {s_en, s_own, s_en && !s_own, s_own};
      got_s = {mem_en, owner, if_r, d_r};
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL starve c%0d en/own/ifr/dr: got %b expected %b", c, got_s, exp_s);
      end
      if (s_en) begin
        checks++;
        if (mem_addr !== (s_own ? 16'h4002 : 16'h3006)) begin
          errors++;
          $display("FAIL starve c%0d mem_addr: got %h expected %h",
                   c, mem_addr, s_own ? 16'h4002 : 16'h3006);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the LC-3b pipeline's single unified memory port between the FETCH-stage instruction read port and the MEM-stage data port. Runs on the pipeline clock `clk`. Serialises accesses, holds address, data and control stable for the full memory latency, and returns a one-cycle completion strobe to the winning requester. Replaces the constant `imem_r` and the `mem_stall` tie-offs currently fed to the pipeline top.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MAX_DATA_STREAK`, 4, consecutive data grants allowed while a fetch waits; range 1..15
- `clk`  in  1  pipeline clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch read request; held until `if_r`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`
- `if_rdata`  out  DATA_W  fetch read data; valid only when `if_r`=1
- `if_r`  out  1  fetch completion strobe, one cycle
- `d_req`  in  1  data request; held until `d_r`
- `d_we`  in  1  1=write, 0=read
- `d_wmask`  in  2  byte enables, [1]=high byte, [0]=low byte
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  read data; valid only when `d_r`=1
- `d_r`  out  1  data completion strobe, one cycle
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write enable
- `mem_wmask`  out  2  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ready`  in  1  memory completes the current access this cycle
- `owner`  out  1  0=fetch, 1=data; meaningful only while `mem_en`=1

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY.
- IDLE with no request: stay in IDLE.
- IDLE with only `if_req`: latch `if_addr` into the memory registers, set `mem_we`=0 and `mem_wmask`=00, go to IF_BUSY.
- IDLE with only `d_req`: latch `d_addr`, `d_we`, `d_wmask` and `d_wdata`, go to D_BUSY.
- IDLE with both requests: data wins, unless `streak`==MAX_DATA_STREAK, in which case fetch wins.
- `streak` (4-bit): increments on a data grant while `if_req`=1; clears on any fetch grant; saturates at MAX_DATA_STREAK.
- IF_BUSY / D_BUSY:
  - `mem_en`=1; `owner` reflects the state.
  - Memory outputs hold the latched values.
  - Wait for `mem_ready`; on `mem_ready`=1 return to IDLE.
- Completion strobes are combinational:
  - `if_r` = IF_BUSY & `mem_ready`; `d_r` = D_BUSY & `mem_ready`.
  - `if_rdata` = `d_rdata` = `mem_rdata` (passthrough).
- Writes also pulse `d_r`. `d_rdata` is don't-care on writes.
- `mem_ready` in IDLE is ignored.
- A request dropped during its own busy phase is a protocol violation. The access still completes and the strobe still fires.
- `d_we`=1 with `d_wmask`=00 is issued to memory unmodified.

## Timing
- Reset values:
  - state=IDLE, `streak`=0.
  - `mem_en`=0, `mem_we`=0, `mem_wmask`=00, `mem_addr`=0, `mem_wdata`=0, `owner`=0.
  - `if_r`=0, `d_r`=0.
- Latency:
  - Request sampled in IDLE at cycle n gives `mem_en`=1 from cycle n+1.
  - Strobe appears in the first cycle m≥n+1 with `mem_ready`=1; state is IDLE at m+1.
- Throughput: at most one access per 2 cycles. IDLE always occupies at least one cycle between accesses.
- Requester handshake: the requester may drop or change its request on the edge ending the strobe cycle. The IDLE cycle samples the updated request.
- Reset during a busy state:
  - Next cycle: IDLE, `mem_en`=0.
  - No strobe is issued; the access is abandoned.
  - `streak` is cleared.
- `reset` has priority over every other input.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x3000, `mem_ready` high on the 3rd busy cycle, `mem_rdata`=0xF025 -> `mem_en`=1 for exactly 3 cycles, `mem_addr`=0x3000, `if_r`=1 only in the 3rd cycle with `if_rdata`=0xF025.
- Simultaneous requests, `streak`=0: `d_req` (read 0x4000) and `if_req` (0x3002) in the same cycle -> `owner`=1 first, `d_r` fires, one IDLE cycle, then fetch of 0x3002.
- Starvation, MAX_DATA_STREAK=4, `mem_ready` tied 1, both requests held continuously -> grant order D,D,D,D,I,D,D,D,D,I; `if_r` every 10th cycle.
- Byte write: `d_we`=1, `d_wmask`=10, `d_addr`=0x4001, `d_wdata`=0xAB00 -> throughout the busy phase `mem_we`=1, `mem_wmask`=10, `mem_wdata`=0xAB00; `d_r` pulses once.
- Reset mid-access: `reset`=1 in the 2nd cycle of D_BUSY -> next cycle `mem_en`=0 and all outputs at reset values; no `d_r`; subsequent `if_req` is granted normally.
- Spurious ready: `mem_ready`=1 while IDLE with no request -> no strobe and `mem_en` stays 0.
